fb_swap_arbiter: RTL
====================

FB_SWAP_ARBITER -- requirements
Module: fb_swap_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL be the per-buffer pixel address width.
REQ-002 Parameter DATA_W, default 16, SHALL be the pixel data width.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL be the write FIFO depth (power of two, >=2).
REQ-004 pixel_clk_in  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-005 rst_in  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 nf_in  input  1  SHALL be the single-cycle new-frame pulse from the video timing generator.
REQ-007 rd_en_in  input  1  SHALL be the display read request for this cycle.
REQ-008 rd_addr_in  input  ADDR_W  SHALL be the display pixel address.
REQ-009 rd_data_out  output  DATA_W  SHALL be the returned display pixel.
REQ-010 rd_valid_out  output  1  SHALL mark rd_data_out valid.
REQ-011 wr_valid_in / wr_ready_out  input / output  1 / 1  SHALL form the writer's valid/ready handshake.
REQ-012 wr_addr_in, wr_data_in  input  ADDR_W, DATA_W  SHALL be the back-buffer write address and data.
REQ-013 commit_in  input  1  SHALL be the writer's single-cycle "back frame complete" pulse.
REQ-014 mem_addr_out  output  ADDR_W+1  SHALL drive the single memory port; MSB is buffer select.
REQ-015 mem_we_out, mem_din_out  output  1, DATA_W  SHALL be the memory write enable and write data.
REQ-016 mem_dout_in  input  DATA_W  SHALL be memory read data, 2-cycle read latency.
REQ-017 front_sel_out  output  1  SHALL be the buffer currently displayed.
REQ-018 stall_count_out  output  16  SHALL count cycles with wr_valid_in=1 and wr_ready_out=0.

Function
REQ-019 Reads SHALL have absolute priority: rd_en_in=1 drives mem_addr_out={front_sel_out, rd_addr_in}, mem_we_out=0 that cycle.
REQ-020 rd_valid_out SHALL equal rd_en_in delayed exactly 2 cycles; rd_data_out SHALL pass mem_dout_in through combinationally.
REQ-021 A write SHALL be accepted into the FIFO on wr_valid_in & wr_ready_out.
REQ-022 wr_ready_out SHALL be 1 only when state=WRITE and FIFO not full (a pop in the same cycle does not free a slot).
REQ-023 FIFO head SHALL pop when rd_en_in=0 and FIFO non-empty, driving mem_addr_out={~front_sel_out, head addr}, mem_we_out=1, mem_din_out=head data.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged; push-to-memory minimum latency 1 cycle; write order SHALL be preserved.
REQ-025 FSM states SHALL be WRITE, DRAIN, ARMED.
REQ-026 WRITE: commit_in=1 SHALL go to DRAIN (same cycle's accepted push is included in the frame).
REQ-027 DRAIN: FIFO empty SHALL go to ARMED; nf_in is ignored in DRAIN.
REQ-028 ARMED: nf_in=1 SHALL toggle front_sel_out on the next edge and return to WRITE.
REQ-029 commit_in outside WRITE SHALL be ignored.
REQ-030 Idle memory cycles (no read, empty FIFO) SHALL drive mem_we_out=0, mem_addr_out={front_sel_out, rd_addr_in}.
REQ-031 stall_count_out SHALL saturate at 16'hFFFF.

Reset
REQ-032 rst_in=1 SHALL immediately force state=WRITE, FIFO empty, front_sel_out=0, stall_count_out=0, read-valid pipeline cleared (rd_valid_out=0), mem_we_out=0.
REQ-033 Reset mid-DRAIN/ARMED SHALL discard FIFO contents and any pending swap.

Structure
REQ-034 FSM state enum and default widths SHALL live in shared package fb_pkg.
REQ-035 Write FIFO SHALL be sub-module fb_wr_fifo (sync FIFO, full/empty flags, same clock/reset).

Verification
REQ-036 Reset, then rd_en_in=1 addr 0x0010 with mem_dout_in=0xABCD two cycles later -> rd_valid_out=1 two cycles after request, rd_data_out=0xABCD, mem_addr_out=0x00010.
REQ-037 rd_en_in held 1 for 10 cycles, 5 writes offered -> 4 accepted, wr_ready_out=0 after, stall_count_out=6 after 10 cycles, no mem_we_out until rd_en_in drops, then 4 writes to buffer 1 in order.
REQ-038 commit_in with 3 entries queued, nf_in during DRAIN -> no swap; after drain, next nf_in -> front_sel_out=1 one cycle later, wr_ready_out returns to 1.
REQ-039 commit_in and nf_in in same cycle from WRITE with empty FIFO -> DRAIN then ARMED; swap only on following nf_in.
REQ-040 rst_in asserted in ARMED with front_sel_out=1 -> front_sel_out=0, FIFO empty, state WRITE asynchronously.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg
//   Shared definitions for the frame-buffer swap arbiter:
//   - default address/data widths and write-FIFO depth
//   - the swap FSM state encoding
//   - a saturating increment helper for the stall counter
package fb_pkg;

    localparam int FB_ADDR_W     = 16;
    localparam int FB_DATA_W     = 16;
    localparam int FB_FIFO_DEPTH = 4;
    localparam int STALL_W       = 16;

    // WRITE: writer fills the back buffer
    // DRAIN: frame committed; flushing queued writes to memory
    // ARMED: back buffer complete; waiting for the next frame start
    typedef enum logic [1:0] {
        WRITE = 2'd0,
        DRAIN = 2'd1,
        ARMED = 2'd2
    } fb_state_e;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo
//   Small synchronous FIFO holding pending back-buffer writes.
//   Head entry is presented combinationally so it can be retired the cycle
//   after it is pushed.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset (empties the FIFO)
//   push_i, din_i    write side (ignored when full)
//   pop_i, dout_o    read side; dout_o is the current head (ignored when empty)
//   full_o, empty_o  occupancy flags
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int WIDTH = FB_ADDR_W + FB_DATA_W,
    parameter int DEPTH = FB_FIFO_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= din_i;
        end
    end

    assign dout_o = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/fb_swap_arbiter.sv
// fb_swap_arbiter
//   Double-buffered frame store arbiter sharing one memory port between the
//   display (reads, absolute priority) and a writer (queued through a FIFO).
//   Swaps front/back buffers on a new-frame pulse once the writer has
//   committed a frame and all of its writes have reached memory.
// Ports:
//   pixel_clk_in, rst_in          clock, asynchronous active-high reset
//   nf_in                         new-frame pulse from video timing
//   rd_en_in, rd_addr_in          display read request / address
//   rd_data_out, rd_valid_out     returned pixel, valid 2 cycles after request
//   wr_valid_in, wr_ready_out     writer handshake
//   wr_addr_in, wr_data_in        back-buffer write address / data
//   commit_in                     writer "back frame complete" pulse
//   mem_addr_out (MSB = buffer), mem_we_out, mem_din_out, mem_dout_in
//                                 single memory port, 2-cycle read latency
//   front_sel_out                 buffer currently displayed
//   stall_count_out               saturating count of writer stall cycles
module fb_swap_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int FIFO_DEPTH = FB_FIFO_DEPTH
) (
    input  logic               pixel_clk_in,
    input  logic               rst_in,
    input  logic               nf_in,
    input  logic               rd_en_in,
    input  logic [ADDR_W-1:0]  rd_addr_in,
    output logic [DATA_W-1:0]  rd_data_out,
    output logic               rd_valid_out,
    input  logic               wr_valid_in,
    output logic               wr_ready_out,
    input  logic [ADDR_W-1:0]  wr_addr_in,
    input  logic [DATA_W-1:0]  wr_data_in,
    input  logic               commit_in,
    output logic [ADDR_W:0]    mem_addr_out,
    output logic               mem_we_out,
    output logic [DATA_W-1:0]  mem_din_out,
    input  logic [DATA_W-1:0]  mem_dout_in,
    output logic               front_sel_out,
    output logic [STALL_W-1:0] stall_count_out
);

    localparam int ENTRY_W = ADDR_W + DATA_W;

    fb_state_e          state_q;
    logic               front_q;
    logic [1:0]         rd_vld_q;
    logic [STALL_W-1:0] stall_q;

    logic               fifo_full, fifo_empty;
    logic               fifo_push, fifo_pop;
    logic [ENTRY_W-1:0] fifo_din, fifo_head;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;

    // Uses the registered full flag, so a pop this cycle does not open a slot
    // for a push in the same cycle.
    assign wr_ready_out = (state_q == WRITE) && !fifo_full;
    assign fifo_push    = wr_valid_in && wr_ready_out;
    // Writes only get the port when the display leaves it idle.
    assign fifo_pop     = !rd_en_in && !fifo_empty;
    assign fifo_din     = {wr_addr_in, wr_data_in};
    assign {head_addr, head_data} = fifo_head;

    fb_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_i   (pixel_clk_in),
        .rst_i   (rst_in),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Memory port mux: writes target the back buffer, everything else
    // (reads and idle cycles) addresses the front buffer.
    assign mem_we_out   = fifo_pop;
    assign mem_addr_out = fifo_pop ? {~front_q, head_addr} : {front_q, rd_addr_in};
    assign mem_din_out  = head_data;

    assign rd_data_out     = mem_dout_in;
    assign rd_valid_out    = rd_vld_q[1];
    assign front_sel_out   = front_q;
    assign stall_count_out = stall_q;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= WRITE;
            front_q  <= 1'b0;
            rd_vld_q <= '0;
            stall_q  <= '0;
        end else begin
            // Matches the memory's fixed 2-cycle read latency.
            rd_vld_q <= {rd_vld_q[0], rd_en_in};

            if (wr_valid_in && !wr_ready_out) begin
                stall_q <= sat_inc(stall_q);
            end

            case (state_q)
                WRITE: begin
                    // A push accepted alongside commit is already in the
                    // FIFO, so DRAIN flushes it with the rest of the frame.
                    if (commit_in) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (nf_in) begin
                        front_q <= ~front_q;
                        state_q <= WRITE;
                    end
                end
                default: state_q <= WRITE;
            endcase
        end
    end

endmodule
